// File: rtl/spram_arbiter.sv
// rtl/spram_arbiter.sv - round-robin arbiter sharing one spram port among NUM_REQ requesters
// Optional requester lock (exclusive multi-cycle ownership) when SPRAM_ARB_LOCK_EN is defined.
module spram_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int SIZE    = 2048,
    localparam int AW     = $clog2(SIZE),
    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef SPRAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       lock,
`endif
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       we,
    input  logic [NUM_REQ*AW-1:0]    addr,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rvalid,
    output logic [WIDTH-1:0]         rdata,
    output logic                     sram_wen,
    output logic                     sram_ren,
    output logic [AW-1:0]            sram_waddr,
    output logic [AW-1:0]            sram_raddr,
    output logic [WIDTH-1:0]         sram_wdata,
    input  logic [WIDTH-1:0]         sram_rdata,
    input  logic                     sram_ready
);

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      rd_owner;
    logic               rd_pend;
    logic [IW-1:0]      start;
    logic [IW-1:0]      g;
    logic [IW-1:0]      cand;
    logic               found;
    logic               gnt_vld;
    logic [NUM_REQ-1:0] req_eff;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

`ifdef SPRAM_ARB_LOCK_EN
    logic          locked;
    logic [IW-1:0] lock_owner;
    logic          unlock;

    // The owner releases the port as soon as it drops req or lock; arbitration
    // then resumes just past the owner in the same cycle.
    always_comb begin
        unlock  = locked && !(req[lock_owner] && lock[lock_owner]);
        req_eff = req;
        start   = ptr;
        if (locked && !unlock) begin
            req_eff = req & (NUM_REQ'(1) << lock_owner);
            start   = lock_owner;
        end else if (unlock) begin
            start   = next_idx(lock_owner);
        end
    end
`else
    always_comb begin
        req_eff = req;
        start   = ptr;
    end
`endif

    always_comb begin
        found = 1'b0;
        g     = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((32'(start) + 32'(k)) % NUM_REQ);
            if (!found && req_eff[cand]) begin
                found = 1'b1;
                g     = cand;
            end
        end
    end

    // Grants are masked during reset so nothing reaches the spram port.
    assign gnt_vld    = found & rst_n;
    assign gnt        = gnt_vld ? (NUM_REQ'(1) << g) : '0;
    assign sram_wen   = gnt_vld & we[g];
    assign sram_ren   = gnt_vld & ~we[g];
    assign sram_waddr = gnt_vld ? addr[int'(g)*AW +: AW] : '0;
    assign sram_raddr = sram_waddr;
    assign sram_wdata = gnt_vld ? wdata[int'(g)*WIDTH +: WIDTH] : '0;

    assign rvalid = (sram_ready && rd_pend) ? (NUM_REQ'(1) << rd_owner) : '0;
    assign rdata  = sram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            rd_owner   <= '0;
            rd_pend    <= 1'b0;
`ifdef SPRAM_ARB_LOCK_EN
            locked     <= 1'b0;
            lock_owner <= '0;
`endif
        end else begin
            rd_pend <= sram_ren;
            if (sram_ren) begin
                rd_owner <= g;
            end
`ifdef SPRAM_ARB_LOCK_EN
            if (gnt_vld) begin
                if (lock[g]) begin
                    locked     <= 1'b1;
                    lock_owner <= g;
                end else begin
                    locked     <= 1'b0;
                    ptr        <= next_idx(g);
                end
            end else if (unlock) begin
                locked <= 1'b0;
                ptr    <= next_idx(lock_owner);
            end
`else
            if (gnt_vld) begin
                ptr <= next_idx(g);
            end
`endif
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// tb/tb_spram_arbiter.sv - scoreboard bench for spram_arbiter with a behavioural spram
module tb_spram_arbiter;
    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 32;
    localparam int SIZE    = 2048;
    localparam int AW      = 11;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       lock;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       we;
    logic [NUM_REQ*AW-1:0]    addr;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       rvalid;
    logic [WIDTH-1:0]         rdata;
    logic                     sram_wen;
    logic                     sram_ren;
    logic [AW-1:0]            sram_waddr;
    logic [AW-1:0]            sram_raddr;
    logic [WIDTH-1:0]         sram_wdata;
    logic [WIDTH-1:0]         sram_rdata;
    logic                     sram_ready;

    spram_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef SPRAM_ARB_LOCK_EN
        .lock       (lock),
`endif
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .sram_wen   (sram_wen),
        .sram_ren   (sram_ren),
        .sram_waddr (sram_waddr),
        .sram_raddr (sram_raddr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ready (sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int a);
        return 32'h1000_0000 + 32'(a) * 32'h0001_0101;
    endfunction

    // Behavioural spram: 1-cycle read with ready, write at the clock edge.
    logic [WIDTH-1:0] mem [0:SIZE-1];
    logic [WIDTH-1:0] mem_q;
    logic             mem_rdy;
    logic             rdy_force;
    assign sram_rdata = mem_q;
    assign sram_ready = mem_rdy | rdy_force;

    always @(posedge clk) begin
        if (sram_wen) mem[sram_waddr] <= sram_wdata;
        if (sram_ren) mem_q <= mem[sram_raddr];
        mem_rdy <= sram_ren;
    end

    typedef struct {
        int          due;
        logic [1:0]  mask;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] shadow [int];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          running = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] expect_data(input int a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every cycle either the front entry is due or rvalid must be idle.
    always @(negedge clk) begin
        if (running && rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("rvalid", 64'(rvalid), 64'(e.mask));
                chk("rdata", 64'(rdata), 64'(e.data));
            end else begin
                chk("rvalid_idle", 64'(rvalid), 64'd0);
            end
        end
    end

    task automatic step(input logic [1:0] r, input logic [1:0] w,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] eg, input bit push, input string tag);
        int          gi;
        logic [AW-1:0] ea;
        logic [31:0] ed;
        logic        ew;
        req   = r;
        we    = w;
        addr  = {a1, a0};
        wdata = {d1, d0};
        @(negedge clk);
        chk({tag, "/gnt"}, 64'(gnt), 64'(eg));
        gi = eg[1] ? 1 : 0;
        ea = (eg == 2'b00) ? '0 : (gi == 1 ? a1 : a0);
        ed = (eg == 2'b00) ? '0 : (gi == 1 ? d1 : d0);
        ew = w[gi];
        chk({tag, "/wen"}, 64'(sram_wen), (eg != 2'b00) ? 64'(ew) : 64'd0);
        chk({tag, "/ren"}, 64'(sram_ren), (eg != 2'b00) ? 64'(!ew) : 64'd0);
        chk({tag, "/waddr"}, 64'(sram_waddr), 64'(ea));
        chk({tag, "/raddr"}, 64'(sram_raddr), 64'(ea));
        chk({tag, "/wdata"}, 64'(sram_wdata), 64'(ed));
        if (eg != 2'b00) begin
            if (ew) shadow[int'(ea)] = ed;
            else if (push) sb.push_back('{cyc + 1, eg, expect_data(int'(ea))});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = init_val(i);
        mem_q     = '0;
        mem_rdy   = 1'b0;
        rdy_force = 1'b0;
        rst_n     = 1'b0;
        lock      = 2'b00;
        req       = 2'b11;
        we        = 2'b00;
        addr      = '0;
        wdata     = '0;

        repeat (2) @(negedge clk);
        chk("rst/gnt", 64'(gnt), 64'd0);
        chk("rst/wen", 64'(sram_wen), 64'd0);
        chk("rst/ren", 64'(sram_ren), 64'd0);
        chk("rst/rvalid", 64'(rvalid), 64'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        running = 1'b1;

        for (int i = 0; i < 4; i++)
            step(2'b11, 2'b00, AW'(10 + i), AW'(20 + i), 32'h0, 32'h0,
                 (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, "contend");

        step(2'b01, 2'b01, 11'h005, 11'h000, 32'hDEAD_BEEF, 32'h0, 2'b01, 1'b1, "wr5");
        step(2'b10, 2'b00, 11'h000, 11'h005, 32'h0, 32'h0, 2'b10, 1'b1, "rd5");

        for (int i = 0; i < 4; i++)
            step(2'b10, 2'b00, 11'h000, AW'(i), 32'h0, 32'h0, 2'b10, 1'b1, "single");
        step(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 1'b1, "idle0");

        step(2'b11, 2'b10, 11'h007, 11'h007, 32'h0, 32'hCAFE_F00D, 2'b01, 1'b1, "rd7_old");
        step(2'b10, 2'b10, 11'h000, 11'h007, 32'h0, 32'hCAFE_F00D, 2'b10, 1'b1, "wr7");
        step(2'b01, 2'b00, 11'h007, 11'h000, 32'h0, 32'h0, 2'b01, 1'b1, "rd7_new");
        step(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 1'b1, "idle1");
        rdy_force = 1'b1;
        step(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 1'b1, "stray_ready");
        rdy_force = 1'b0;

        // Read granted to requester 0 (ptr moves to 1), then reset lands on its return cycle.
        step(2'b01, 2'b00, 11'h003, 11'h000, 32'h0, 32'h0, 2'b01, 1'b0, "rst_rd");
        rst_n = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        chk("rst_mid/rvalid", 64'(rvalid), 64'd0);
        chk("rst_mid/gnt", 64'(gnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rdy_force = 1'b1;
        step(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 1'b1, "post_rst_idle");
        rdy_force = 1'b0;
        step(2'b11, 2'b00, 11'h00A, 11'h00B, 32'h0, 32'h0, 2'b01, 1'b1, "post_rst_ptr");
        step(2'b10, 2'b00, 11'h000, 11'h00C, 32'h0, 32'h0, 2'b10, 1'b1, "realign");

`ifdef SPRAM_ARB_LOCK_EN
        lock = 2'b01;
        for (int i = 0; i < 3; i++)
            step(2'b11, 2'b00, AW'(30 + i), AW'(40 + i), 32'h0, 32'h0, 2'b01, 1'b1, "locked");
        lock = 2'b00;
        step(2'b11, 2'b00, 11'h021, 11'h029, 32'h0, 32'h0, 2'b10, 1'b1, "unlock");
`endif

        step(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 1'b1, "drain0");
        step(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0, 2'b00, 1'b1, "drain1");
        chk("sb_empty", 64'(sb.size()), 64'd0);
        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Round-robin arbiter sharing one spram instance (1-cycle read, 1-cycle write, single access per cycle) among NUM_REQ requesters.
- Sits between requester blocks and the spram port.
- Grants one request per cycle, drives the spram control/address/data signals, and routes the returned read data back to the requester that issued the read.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 32, data width; must match spram WIDTH.
- SIZE, 2048, spram depth; AW = $clog2(SIZE).
- IW, derived, max($clog2(NUM_REQ),1), requester index width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester access request, held until granted
- we  input  NUM_REQ  per-requester access type: 1=write, 0=read
- addr  input  NUM_REQ*AW  per-requester address, requester i at [i*AW +: AW]
- wdata  input  NUM_REQ*WIDTH  per-requester write data, slice i as for addr
- gnt  output  NUM_REQ  one-hot grant, same cycle as accepted request
- rvalid  output  NUM_REQ  one-hot read-data-valid
- rdata  output  WIDTH  read data, broadcast to all requesters; qualify with rvalid
- sram_wen  output  1  to spram wen
- sram_ren  output  1  to spram ren
- sram_waddr  output  AW  to spram waddr
- sram_raddr  output  AW  to spram raddr
- sram_wdata  output  WIDTH  to spram wdata
- sram_rdata  input  WIDTH  from spram rdata
- sram_ready  input  1  from spram ready

Behaviour:
- Registers:
  - ptr [IW]: highest-priority requester.
  - rd_owner [IW]: owner of the in-flight read.
  - rd_pend [1]: a read is in flight.
- Reset values: all three registers 0. While rst_n=0, gnt=0, sram_wen=0, sram_ren=0, rvalid=0.
- Grant selection (combinational):
  - Scan requesters ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - The first with req=1 gets gnt. At most one gnt bit set; gnt=0 if req=0.
- SRAM drive for granted requester g:
  - sram_waddr = sram_raddr = addr[g] and sram_wdata = wdata[g].
  - sram_wen = we[g], sram_ren = ~we[g].
  - With no grant: sram_wen=0, sram_ren=0, addresses/data 0.
- Pointer update on a grant to g: ptr <= (g+1) mod NUM_REQ (wraps NUM_REQ-1 -> 0). No grant: ptr holds.
- Read tracking:
  - On a read grant: rd_owner <= g, rd_pend <= 1. Otherwise rd_pend <= 0.
  - Reads are pipelined; back-to-back reads from different requesters each get their own rvalid.
- Read return:
  - rvalid[rd_owner] = sram_ready & rd_pend; all other bits 0. rdata = sram_rdata.
  - Latency: gnt in cycle N, rvalid/rdata in cycle N+1.
- Write completes at the clock edge of the grant cycle. A read of the same address granted the next cycle returns the new data.
- Requester protocol: the requester holds req/we/addr/wdata stable until gnt. It deasserts req, or presents the next request, in the cycle after gnt.
- Single requester with continuous req: granted every cycle (full throughput).
- Reset mid-read: rd_pend cleared, and no rvalid is issued for the dropped read.
- sram_ready=1 with rd_pend=0 (protocol error): ignored, rvalid=0.

Optional Feature:
- Macro SPRAM_ARB_LOCK_EN.
- Defined:
  - Adds input lock [NUM_REQ].
  - If the granted requester g has lock[g]=1 at grant, set locked <= 1 and lock_owner <= g. ptr is not advanced.
  - While locked: only lock_owner can be granted; other requesters wait.
  - locked clears on the first cycle lock_owner has req=0 or lock=0. ptr then advances to lock_owner+1.
  - Reset: locked=0.
- Not defined: no lock port; pure round-robin as above.

Test Plan:
- Reset: rst_n=0 with req=2'b11 -> gnt=0, sram_wen=0, sram_ren=0, rvalid=0. After release, first grant goes to requester 0 (ptr=0).
- Contention: req=2'b11 held for 4 cycles, all reads -> gnt sequence 01,10,01,10. Each rvalid arrives one cycle after its gnt, on the matching bit.
- Write then read: req0 writes addr 0x005 data 0xDEADBEEF. Next cycle req1 reads 0x005 -> rvalid=2'b10 with rdata=0xDEADBEEF one cycle later.
- Single requester: req=2'b10 continuous reads of addr 0..3 for 4 cycles -> gnt[1] every cycle, 4 consecutive rvalid[1] pulses, rdata in address order.
- Reset mid-read: assert rst_n=0 in the cycle after a read grant -> no rvalid. After release, ptr=0 and rd_pend=0.
- SPRAM_ARB_LOCK_EN defined: req=2'b11, lock=2'b01 for 3 cycles -> gnt=01 for 3 cycles. Then lock=0 -> next gnt=10.
